// File: rtl/cache_mem_pkg.sv
// Shared definitions for the direct-mapped cache and its RAM-side controller:
// state encoding, default geometry and the read-latency counter sizing.
package cache_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } mem_state_t;

    localparam int DEF_ADDRESS_SPACE = 12;
    localparam int DEF_DATA_SIZE     = 32;

    localparam int MAX_READ_LATENCY  = 7;
    localparam int LAT_W             = 3;

endpackage

// File: rtl/cache_ram_controller.sv
// Serves cache line fetches and write-through flushes against a synchronous
// block RAM; one single-cycle acknowledge per request, all outputs registered.
module cache_ram_controller
    import cache_mem_pkg::*;
#(
    parameter int ADDRESS_SPACE = DEF_ADDRESS_SPACE,
    parameter int DATA_SIZE     = DEF_DATA_SIZE,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clka,
    input  logic                     rsta,
    input  logic                     fetch,
    input  logic                     flush,
    input  logic [ADDRESS_SPACE-1:0] addra,
    input  logic [DATA_SIZE-1:0]     dina,
    output logic [DATA_SIZE-1:0]     douta,
    output logic                     fetch_ack,
    output logic                     flush_ack,
    output logic                     busy,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_SPACE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]     mem_wdata,
    input  logic [DATA_SIZE-1:0]     mem_rdata
);

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("cache_ram_controller: READ_LATENCY must be 1..%0d", MAX_READ_LATENCY);
    end

    mem_state_t       state;
    logic [LAT_W-1:0] lat_cnt;
    logic             served_flush;

    always_ff @(posedge clka) begin
        if (rsta) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            served_flush <= 1'b0;
            douta        <= '0;
            fetch_ack    <= 1'b0;
            flush_ack    <= 1'b0;
            busy         <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            fetch_ack <= 1'b0;
            flush_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // flush first: a pending fetch of the same line must see the new data
                    if (flush) begin
                        mem_addr     <= addra;
                        mem_wdata    <= dina;
                        mem_en       <= 1'b1;
                        mem_we       <= 1'b1;
                        served_flush <= 1'b1;
                        busy         <= 1'b1;
                        state        <= WRITE;
                    end else if (fetch) begin
                        mem_addr     <= addra;
                        mem_en       <= 1'b1;
                        mem_we       <= 1'b0;
                        lat_cnt      <= LAT_W'(READ_LATENCY);
                        served_flush <= 1'b0;
                        busy         <= 1'b1;
                        state        <= READ;
                    end
                end
                WRITE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    flush_ack <= 1'b1;
                    state     <= RELEASE;
                end
                READ: begin
                    mem_en <= 1'b0;
                    if (lat_cnt == '0) begin
                        douta     <= mem_rdata;
                        fetch_ack <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    // hold off until the served request drops so it is not served twice
                    if (served_flush ? !flush : !fetch) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
